// File: rtl/decode_scoreboard.sv
// Decode-stage scalar register file, condition-code register and pending-write scoreboard.
// Define DECODE_SCOREBOARD_BYPASS_EN to forward same-cycle writebacks into resolving operands.
module decode_scoreboard #(
    parameter int NUM_REGS     = 16,
    parameter int DATA_W       = 16,
    parameter int NUM_SRC      = 2,
    parameter int MAX_INFLIGHT = 3,
    localparam int IDX_W       = $clog2(NUM_REGS),
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      I_CLOCK,
    input  logic                      I_RESET,
    input  logic                      I_IssueValid,
    input  logic [NUM_SRC*IDX_W-1:0]  I_SrcIdx,
    input  logic [NUM_SRC-1:0]        I_SrcUsed,
    input  logic [IDX_W-1:0]          I_DestIdx,
    input  logic                      I_DestWrite,
    input  logic                      I_ReadsCC,
    input  logic                      I_WritesCC,
    input  logic                      I_Stall,
    input  logic                      I_WBValid,
    input  logic [IDX_W-1:0]          I_WBIdx,
    input  logic [DATA_W-1:0]         I_WBData,
    input  logic                      I_WBCCEn,
    input  logic [2:0]                I_WBCC,
    output logic                      O_Issue,
    output logic [NUM_SRC*DATA_W-1:0] O_SrcValue,
    output logic [2:0]                O_CCValue,
    output logic [IDX_W-1:0]          O_DestIdx,
    output logic                      O_DepStall,
    output logic                      O_Error
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0]         rf [NUM_REGS];
    logic [CNT_W-1:0]          cnt [NUM_REGS];
    logic [CNT_W-1:0]          cnt_next [NUM_REGS];
    logic [2:0]                cc;
    logic [CNT_W-1:0]          cc_cnt;
    logic [CNT_W-1:0]          cc_cnt_next;
    logic                      hazard;
    logic                      accept;
    logic                      underflow;
    logic [NUM_SRC*DATA_W-1:0] src_next;
    logic [2:0]                cc_next;

    // Hazard detection and operand selection, all from current-cycle state.
    // NOTE: combinational blocks use blocking '=' with a default for every output first,
    // so each path is fully assigned and no latch is inferred.
    always_comb begin
        logic [IDX_W-1:0] idx;
        hazard   = 1'b0;
        src_next = '0;
        cc_next  = cc;
        idx      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = I_SrcIdx[k*IDX_W +: IDX_W];
            if (I_SrcUsed[k]) begin
`ifdef DECODE_SCOREBOARD_BYPASS_EN
                if (cnt[idx] == CNT_ONE && I_WBValid && I_WBIdx == idx) begin
                    src_next[k*DATA_W +: DATA_W] = I_WBData;
                end else begin
                    if (cnt[idx] != '0) hazard = 1'b1;
                    src_next[k*DATA_W +: DATA_W] = rf[idx];
                end
`else
                if (cnt[idx] != '0) hazard = 1'b1;
                src_next[k*DATA_W +: DATA_W] = rf[idx];
`endif
            end
        end
        if (I_ReadsCC) begin
`ifdef DECODE_SCOREBOARD_BYPASS_EN
            if (cc_cnt == CNT_ONE && I_WBCCEn) begin
                cc_next = I_WBCC;
            end else if (cc_cnt != '0) begin
                hazard = 1'b1;
            end
`else
            if (cc_cnt != '0) hazard = 1'b1;
`endif
        end
        if (I_DestWrite && cnt[I_DestIdx] == CNT_MAX) hazard = 1'b1;
        if (I_WritesCC && cc_cnt == CNT_MAX) hazard = 1'b1;
    end

    assign O_DepStall = I_IssueValid & hazard;
    assign accept     = I_IssueValid & ~hazard & ~I_Stall;

    // Pending counters: an accepted writer and a retiring writeback on the same entry cancel.
    always_comb begin
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc = accept && I_DestWrite && (I_DestIdx == IDX_W'(i));
            dec = I_WBValid && (I_WBIdx == IDX_W'(i)) && (cnt[i] != '0);
            cnt_next[i] = cnt[i];
            if (inc && !dec)      cnt_next[i] = cnt[i] + CNT_ONE;
            else if (!inc && dec) cnt_next[i] = cnt[i] - CNT_ONE;
        end
        inc = accept && I_WritesCC;
        dec = I_WBCCEn && (cc_cnt != '0);
        cc_cnt_next = cc_cnt;
        if (inc && !dec)      cc_cnt_next = cc_cnt + CNT_ONE;
        else if (!inc && dec) cc_cnt_next = cc_cnt - CNT_ONE;
        underflow = (I_WBValid && cnt[I_WBIdx] == '0) || (I_WBCCEn && cc_cnt == '0);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            // NOTE: the register file is reset explicitly because consumers may legally read
            // a never-written register and must see zero; this costs a reset path per entry.
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i]  <= '0;
                cnt[i] <= '0;
            end
            cc         <= '0;
            cc_cnt     <= '0;
            O_Issue    <= 1'b0;
            O_SrcValue <= '0;
            O_CCValue  <= '0;
            O_DestIdx  <= '0;
            O_Error    <= 1'b0;
        end else begin
            O_Issue <= accept;
            if (accept) begin
                O_SrcValue <= src_next;
                O_CCValue  <= cc_next;
                O_DestIdx  <= I_DestIdx;
            end
            if (I_WBValid) rf[I_WBIdx] <= I_WBData;
            if (I_WBCCEn)  cc <= I_WBCC;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            cc_cnt <= cc_cnt_next;
            if (underflow) O_Error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed, table-driven bench for decode_scoreboard at default parameters.
// Expectations follow DECODE_SCOREBOARD_BYPASS_EN when it is defined.
module tb_decode_scoreboard;

`ifdef DECODE_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [7:0]  src_idx;
    logic [1:0]  src_used;
    logic [3:0]  dest_idx;
    logic        dest_write;
    logic        reads_cc;
    logic        writes_cc;
    logic        stall;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic [15:0] wb_data;
    logic        wb_cc_en;
    logic [2:0]  wb_cc;
    logic        issue;
    logic [31:0] src_value;
    logic [2:0]  cc_value;
    logic [3:0]  o_dest;
    logic        dep_stall;
    logic        error;

    always #5 clk = ~clk;

    decode_scoreboard dut (
        .I_CLOCK      (clk),
        .I_RESET      (rst),
        .I_IssueValid (iv),
        .I_SrcIdx     (src_idx),
        .I_SrcUsed    (src_used),
        .I_DestIdx    (dest_idx),
        .I_DestWrite  (dest_write),
        .I_ReadsCC    (reads_cc),
        .I_WritesCC   (writes_cc),
        .I_Stall      (stall),
        .I_WBValid    (wb_valid),
        .I_WBIdx      (wb_idx),
        .I_WBData     (wb_data),
        .I_WBCCEn     (wb_cc_en),
        .I_WBCC       (wb_cc),
        .O_Issue      (issue),
        .O_SrcValue   (src_value),
        .O_CCValue    (cc_value),
        .O_DestIdx    (o_dest),
        .O_DepStall   (dep_stall),
        .O_Error      (error)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [1:0]  used;
        logic [3:0]  dest;
        logic        dw;
        logic        rcc;
        logic        wcc;
        logic        stall;
        logic        wbv;
        logic [3:0]  wbi;
        logic [15:0] wbd;
        logic        wbccen;
        logic [2:0]  wbcc;
        logic        e_stall;
        logic        e_issue;
        logic [31:0] e_src;
        logic [2:0]  e_cc;
        logic        e_err;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         n     = 0;
    logic [2:0] cur_cc;
    vec_t       tbl [13];
    vec_t       v;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv_i, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [1:0] used, input logic [3:0] dest, input logic dw,
                                input logic wbv, input logic [3:0] wbi, input logic [15:0] wbd,
                                input logic e_stall, input logic e_issue, input logic [31:0] e_src,
                                input logic e_err);
        vec_t r;
        r = '{default: '0};
        r.iv = iv_i; r.s0 = s0; r.s1 = s1; r.used = used; r.dest = dest; r.dw = dw;
        r.wbv = wbv; r.wbi = wbi; r.wbd = wbd;
        r.e_stall = e_stall; r.e_issue = e_issue; r.e_src = e_src; r.e_err = e_err;
        r.e_cc = cur_cc;
        return r;
    endfunction

    task automatic drive(input vec_t d);
        iv = d.iv; src_idx = {d.s1, d.s0}; src_used = d.used; dest_idx = d.dest;
        dest_write = d.dw; reads_cc = d.rcc; writes_cc = d.wcc; stall = d.stall;
        wb_valid = d.wbv; wb_idx = d.wbi; wb_data = d.wbd; wb_cc_en = d.wbccen; wb_cc = d.wbcc;
    endtask

    // One cycle: drive at negedge, check the combinational stall, then registered outputs after posedge.
    task automatic step(input vec_t d);
        n++;
        @(negedge clk);
        drive(d);
        #1 check("dep_stall", n, 32'(dep_stall), 32'(d.e_stall));
        @(posedge clk);
        #1;
        check("issue", n, 32'(issue), 32'(d.e_issue));
        if (d.e_issue) begin
            check("src_value", n, src_value, d.e_src);
            check("cc_value", n, 32'(cc_value), 32'(d.e_cc));
            check("dest_idx", n, 32'(o_dest), 32'(d.dest));
        end
        check("error", n, 32'(error), 32'(d.e_err));
    endtask

    initial begin
        cur_cc = 3'd0;
        rst = 1'b1;
        drive('{default: '0});

        // Basic issue, CC dependency and downstream stall.
        tbl[0]  = mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 16'h0000, 0, 1, 32'h0, 0);
        tbl[1]  = mk(1, 0, 0, 2'b00, 5, 1, 1, 3, 16'h0011, 0, 1, 32'h0, 0);
        tbl[2]  = mk(0, 0, 0, 2'b00, 0, 0, 1, 5, 16'h0022, 0, 0, 32'h0, 0);
        tbl[3]  = mk(1, 3, 5, 2'b11, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0022_0011, 0);
        tbl[4]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0, 0);
        tbl[4].wcc = 1'b1;
        tbl[5]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 1, 0, 32'h0, 0);
        tbl[5].rcc = 1'b1;
        tbl[6]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0);
        tbl[6].wbccen = 1'b1; tbl[6].wbcc = 3'd5;
        tbl[7]  = mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_0011, 0);
        tbl[7].rcc = 1'b1;
        tbl[8]  = mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 16'h0000, 0, 0, 32'h0, 0);
        tbl[8].stall = 1'b1;
        tbl[9]  = tbl[8];
        tbl[10] = mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 16'h0000, 0, 1, 32'h0000_0022, 0);
        tbl[11] = mk(0, 0, 0, 2'b00, 0, 0, 1, 6, 16'h0066, 0, 0, 32'h0, 0);
        tbl[12] = mk(1, 6, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_0066, 0);
        for (int i = 7; i < 13; i++) tbl[i].e_cc = 3'd5;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue", 0, 32'(issue), 32'h0);
        check("rst_src", 0, src_value, 32'h0);
        check("rst_cc", 0, 32'(cc_value), 32'h0);
        check("rst_dest", 0, 32'(o_dest), 32'h0);
        check("rst_error", 0, 32'(error), 32'h0);
        check("rst_dep_stall", 0, 32'(dep_stall), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) step(tbl[i]);
        cur_cc = 3'd5;

        // Read-after-write on R4 resolved by writeback 0x00AA.
        step(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 16'h0000, 0, 1, 32'h0, 0));
        step(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 1, 0, 32'h0, 0));
        step(mk(0, 4, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 0, 32'h0, 0));
        v = mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 1, 0, 32'h0, 0);
        v.stall = 1'b1;
        step(v);
        step(mk(1, 4, 0, 2'b01, 0, 0, 1, 4, 16'h00AA, !BYP, BYP, BYP ? 32'h00AA : 32'h0, 0));
`ifndef DECODE_SCOREBOARD_BYPASS_EN
        step(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_00AA, 0));
`endif

        // Saturation of R2 at three outstanding writers.
        repeat (3) step(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 16'h0000, 0, 1, 32'h0, 0));
        step(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 16'h0000, 1, 0, 32'h0, 0));
        step(mk(1, 0, 0, 2'b00, 2, 1, 1, 2, 16'h0202, 1, 0, 32'h0, 0));
        step(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 16'h0000, 0, 1, 32'h0, 0));
        step(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 16'h0000, 1, 0, 32'h0, 0));
        repeat (3) step(mk(0, 0, 0, 2'b00, 0, 0, 1, 2, 16'h0222, 0, 0, 32'h0, 0));
        step(mk(1, 2, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_0222, 0));

        // Same-cycle accept and writeback on R7 leave its count at one.
        step(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 16'h0000, 0, 1, 32'h0, 0));
        step(mk(1, 0, 0, 2'b00, 7, 1, 1, 7, 16'h0077, 0, 1, 32'h0, 0));
        step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 1, 0, 32'h0, 0));
        step(mk(1, 7, 0, 2'b01, 0, 0, 1, 7, 16'h0777, !BYP, BYP, BYP ? 32'h0777 : 32'h0, 0));
`ifndef DECODE_SCOREBOARD_BYPASS_EN
        step(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_0777, 0));
`endif

        // Underflow on R9 is sticky and the write still lands.
        step(mk(0, 0, 0, 2'b00, 0, 0, 1, 9, 16'h0099, 0, 0, 32'h0, 1));
        step(mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0000_0099, 1));
        repeat (2) step(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0000, 0, 0, 32'h0, 1));

        // Reset overrides a simultaneous issue and writeback.
        @(negedge clk);
        drive(mk(1, 9, 0, 2'b01, 0, 0, 1, 9, 16'h1234, 0, 0, 32'h0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_issue", n, 32'(issue), 32'h0);
        check("rst2_error", n, 32'(error), 32'h0);
        check("rst2_src", n, src_value, 32'h0);
        rst = 1'b0;
        cur_cc = 3'd0;
        step(mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h0, 0));
        drive('{default: '0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
